// File: rtl/overlay_pkg.sv
// Shared types and constants for the overlay position scheduler.
package overlay_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    WARMUP    = 2'd1,
    RUN       = 2'd2
  } ovl_state_t;

  localparam int   COORD_W   = 10;
  localparam logic TGT_BOX   = 1'b0;
  localparam logic TGT_CROSS = 1'b1;

endpackage

// File: rtl/overlay_rr_arb.sv
// Two-requester round-robin arbiter. The priority pointer only matters when
// both requesters are eligible; after an accept it passes to the loser.
module overlay_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_elig,
  input  logic       i_advance,
  output logic [1:0] o_grant
);

  logic r_ptr;

  // One-hot grant: a lone eligible requester wins, a tie goes to the pointer
  always_comb begin
    o_grant = i_elig;
    if (i_elig == 2'b11) begin
      o_grant = r_ptr ? 2'b10 : 2'b01;
    end
  end

  // Hand priority to the requester that did not win the accepted transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_advance) begin
      r_ptr <= o_grant[0];
    end
  end

endmodule

// File: rtl/overlay_sched.sv
// Frame-synchronous position scheduler for the box and crosshair overlays.
// Updates are arbitrated into shadow registers and committed on vsync so the
// renderers never see a position change mid-frame. Video stays gated until
// the clock wizard locks and a number of warm-up frames have passed.
module overlay_sched
  import overlay_pkg::*;
#(
  parameter int   H_ACTIVE     = 640,
  parameter int   V_ACTIVE     = 480,
  parameter logic VS_POL       = 1'b0,
  parameter int   BLANK_FRAMES = 2,
  parameter int   BOX_X0       = 320,
  parameter int   BOX_Y0       = 240,
  parameter int   CROSS_X0     = 320,
  parameter int   CROSS_Y0     = 240
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               vsync,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic               req0_sel,
  input  logic [COORD_W-1:0] req0_x,
  input  logic [COORD_W-1:0] req0_y,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic               req1_sel,
  input  logic [COORD_W-1:0] req1_x,
  input  logic [COORD_W-1:0] req1_y,
  output logic [COORD_W-1:0] box_x,
  output logic [COORD_W-1:0] box_y,
  output logic [COORD_W-1:0] cross_x,
  output logic [COORD_W-1:0] cross_y,
  output logic               video_en,
  output logic               commit_pulse,
  output logic               pend_box,
  output logic               pend_cross,
  output logic [15:0]        frame_cnt
);

  localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] Y_LIM     = COORD_W'(V_ACTIVE - 1);
  localparam logic [3:0]         WARM_LAST = 4'(BLANK_FRAMES - 1);

  // Saturate a requested coordinate to the last visible pixel
  function automatic logic [COORD_W-1:0] sat_coord(
    input logic [COORD_W-1:0] v,
    input logic [COORD_W-1:0] lim
  );
    return (v > lim) ? lim : v;
  endfunction

  ovl_state_t                r_state;
  ovl_state_t                w_state_nxt;
  logic [3:0]                r_wcnt;
  logic [3:0]                w_wcnt_nxt;
  logic                      r_vs_prev;
  logic                      w_vs_act;
  logic                      w_vs_edge;
  logic                      w_active;
  logic                      w_commit;
  logic [1:0]                r_pend;
  logic [1:0]                w_pend_nxt;
  logic [1:0][COORD_W-1:0]   r_sh_x;
  logic [1:0][COORD_W-1:0]   r_sh_y;
  logic [1:0][COORD_W-1:0]   r_pos_x;
  logic [1:0][COORD_W-1:0]   r_pos_y;
  logic                      r_video_en;
  logic                      r_commit;
  logic [15:0]               r_frame;
  logic [1:0]                w_elig;
  logic [1:0]                w_grant;
  logic                      w_acc0;
  logic                      w_acc1;
  logic                      w_acc;
  logic                      w_acc_sel;
  logic [COORD_W-1:0]        w_acc_x;
  logic [COORD_W-1:0]        w_acc_y;

  assign w_vs_act  = (vsync == VS_POL);
  assign w_vs_edge = w_vs_act && !r_vs_prev;
  assign w_active  = (r_state != WAIT_LOCK);
  // Loss of lock suppresses the commit in the same cycle
  assign w_commit  = w_vs_edge && w_active && locked;

  // A requester competes only if its target has no update already waiting
  assign w_elig[0] = req0_valid && !r_pend[req0_sel];
  assign w_elig[1] = req1_valid && !r_pend[req1_sel];

  overlay_rr_arb u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_elig    (w_elig),
    .i_advance (w_acc),
    .o_grant   (w_grant)
  );

  assign req0_ready = w_active && w_grant[0];
  assign req1_ready = w_active && w_grant[1];
  assign w_acc0     = req0_valid && req0_ready;
  assign w_acc1     = req1_valid && req1_ready;
  assign w_acc      = w_acc0 || w_acc1;
  assign w_acc_sel  = w_acc1 ? req1_sel : req0_sel;
  assign w_acc_x    = sat_coord(w_acc1 ? req1_x : req0_x, X_LIM);
  assign w_acc_y    = sat_coord(w_acc1 ? req1_y : req0_y, Y_LIM);

  // Start-up sequencing: wait for lock, count warm-up frames, then run
  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    unique case (r_state)
      WAIT_LOCK: begin
        w_wcnt_nxt = '0;
        if (locked) w_state_nxt = WARMUP;
      end
      WARMUP: begin
        if (w_vs_edge) begin
          if (r_wcnt == WARM_LAST) begin
            w_state_nxt = RUN;
            w_wcnt_nxt  = '0;
          end else begin
            w_wcnt_nxt = r_wcnt + 4'd1;
          end
        end
      end
      RUN: begin
        w_wcnt_nxt = '0;
      end
      default: begin
        w_state_nxt = WAIT_LOCK;
        w_wcnt_nxt  = '0;
      end
    endcase
    if (!locked) begin
      w_state_nxt = WAIT_LOCK;
      w_wcnt_nxt  = '0;
    end
  end

  // Pending flags: a commit drains every shadow, an accept refills one target
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_commit) w_pend_nxt = 2'b00;
    if (w_acc) w_pend_nxt[w_acc_sel] = 1'b1;
    if (!locked) w_pend_nxt = 2'b00;
  end

  // Control state, committed positions and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state            <= WAIT_LOCK;
      r_wcnt             <= '0;
      r_vs_prev          <= 1'b1;
      r_pend             <= 2'b00;
      r_video_en         <= 1'b0;
      r_commit           <= 1'b0;
      r_frame            <= '0;
      r_pos_x[TGT_BOX]   <= COORD_W'(BOX_X0);
      r_pos_y[TGT_BOX]   <= COORD_W'(BOX_Y0);
      r_pos_x[TGT_CROSS] <= COORD_W'(CROSS_X0);
      r_pos_y[TGT_CROSS] <= COORD_W'(CROSS_Y0);
    end else begin
      r_state    <= w_state_nxt;
      r_wcnt     <= w_wcnt_nxt;
      r_vs_prev  <= w_vs_act;
      r_pend     <= w_pend_nxt;
      r_video_en <= (w_state_nxt == RUN);
      r_commit   <= w_commit && (|r_pend);
      if (w_commit && (r_state == RUN)) r_frame <= r_frame + 16'd1;
      if (w_commit && r_pend[TGT_BOX]) begin
        r_pos_x[TGT_BOX] <= r_sh_x[TGT_BOX];
        r_pos_y[TGT_BOX] <= r_sh_y[TGT_BOX];
      end
      if (w_commit && r_pend[TGT_CROSS]) begin
        r_pos_x[TGT_CROSS] <= r_sh_x[TGT_CROSS];
        r_pos_y[TGT_CROSS] <= r_sh_y[TGT_CROSS];
      end
    end
  end

  // Shadow capture; contents only matter while the matching pending flag is set
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_sh_x[w_acc_sel] <= w_acc_x;
      r_sh_y[w_acc_sel] <= w_acc_y;
    end
  end

  assign box_x        = r_pos_x[TGT_BOX];
  assign box_y        = r_pos_y[TGT_BOX];
  assign cross_x      = r_pos_x[TGT_CROSS];
  assign cross_y      = r_pos_y[TGT_CROSS];
  assign video_en     = r_video_en;
  assign commit_pulse = r_commit;
  assign pend_box     = r_pend[TGT_BOX];
  assign pend_cross   = r_pend[TGT_CROSS];
  assign frame_cnt    = r_frame;

endmodule

// File: tb/tb_overlay_sched.sv
// Bench for overlay_sched: directed start-up/commit scenarios with literal
// expectations, then randomized traffic against a behavioural frame model.
module tb_overlay_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       locked = 1'b0;
  logic       vsync = 1'b1;
  logic       req0_valid = 1'b0, req0_sel = 1'b0;
  logic       req1_valid = 1'b0, req1_sel = 1'b0;
  logic [9:0] req0_x = '0, req0_y = '0, req1_x = '0, req1_y = '0;
  logic       req0_ready, req1_ready;
  logic [9:0] box_x, box_y, cross_x, cross_y;
  logic       video_en, commit_pulse, pend_box, pend_cross;
  logic [15:0] frame_cnt;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  overlay_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .locked       (locked),
    .vsync        (vsync),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_sel     (req0_sel),
    .req0_x       (req0_x),
    .req0_y       (req0_y),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_sel     (req1_sel),
    .req1_x       (req1_x),
    .req1_y       (req1_y),
    .box_x        (box_x),
    .box_y        (box_y),
    .cross_x      (cross_x),
    .cross_y      (cross_y),
    .video_en     (video_en),
    .commit_pulse (commit_pulse),
    .pend_box     (pend_box),
    .pend_cross   (pend_cross),
    .frame_cnt    (frame_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 = waiting for lock, 1 = warm-up, 2 = running
  int m_mode, m_warm, m_ptr, m_frame;
  bit m_prev, m_video, m_pulse;
  bit m_pend[2];
  int m_pos_x[2], m_pos_y[2], m_sh_x[2], m_sh_y[2];

  task automatic model_reset();
    m_mode = 0; m_warm = 0; m_ptr = 0; m_frame = 0;
    m_prev = 1'b1; m_video = 1'b0; m_pulse = 1'b0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_pos_x[0] = 320; m_pos_y[0] = 240;
    m_pos_x[1] = 320; m_pos_y[1] = 240;
  endtask

  function automatic int m_winner();
    bit e0, e1;
    e0 = req0_valid && !m_pend[req0_sel];
    e1 = req1_valid && !m_pend[req1_sel];
    if (e0 && e1) return m_ptr;
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  task automatic model_step(input int w);
    bit act, ev, acc;
    int tg, ax, ay;
    tg = 0; ax = 0; ay = 0;
    act    = (vsync == 1'b0);
    ev     = act && !m_prev;
    m_prev = act;
    acc    = (m_mode != 0) && (w >= 0);
    if (acc) begin
      tg = (w == 0) ? int'(req0_sel) : int'(req1_sel);
      ax = (w == 0) ? int'(req0_x) : int'(req1_x);
      ay = (w == 0) ? int'(req0_y) : int'(req1_y);
      if (ax > 639) ax = 639;
      if (ay > 479) ay = 479;
    end
    if (!locked) begin
      if (acc) begin
        m_sh_x[tg] = ax; m_sh_y[tg] = ay; m_ptr = 1 - w;
      end
      m_mode = 0; m_warm = 0; m_video = 1'b0; m_pulse = 1'b0;
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    end else begin
      m_pulse = 1'b0;
      if (ev && m_mode != 0) begin
        m_pulse = m_pend[0] || m_pend[1];
        for (int t = 0; t < 2; t++) begin
          if (m_pend[t]) begin
            m_pos_x[t] = m_sh_x[t]; m_pos_y[t] = m_sh_y[t]; m_pend[t] = 1'b0;
          end
        end
        if (m_mode == 2) m_frame = (m_frame + 1) % 65536;
      end
      if (acc) begin
        m_sh_x[tg] = ax; m_sh_y[tg] = ay; m_pend[tg] = 1'b1; m_ptr = 1 - w;
      end
      if (m_mode == 0) m_mode = 1;
      else if (m_mode == 1 && ev) begin
        m_warm++;
        if (m_warm == 2) m_mode = 2;
      end
      m_video = (m_mode == 2);
    end
  endtask

  // Compare every cycle on the inactive edge, then advance the model
  always @(negedge clk) begin
    int w;
    if (!rst_n) model_reset();
    w = m_winner();
    check("m ready0", req0_ready, (m_mode != 0) && (w == 0));
    check("m ready1", req1_ready, (m_mode != 0) && (w == 1));
    check("m box_x", box_x, m_pos_x[0]);
    check("m box_y", box_y, m_pos_y[0]);
    check("m cross_x", cross_x, m_pos_x[1]);
    check("m cross_y", cross_y, m_pos_y[1]);
    check("m video_en", video_en, m_video);
    check("m commit_pulse", commit_pulse, m_pulse);
    check("m pend_box", pend_box, m_pend[0]);
    check("m pend_cross", pend_cross, m_pend[1]);
    check("m frame_cnt", frame_cnt, m_frame);
    model_step(w);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic vs_pulse();
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    cyc(2);
  endtask

  initial begin
    int vs_cnt, lock_cnt;
    vs_cnt = 0; lock_cnt = 0;
    #1 rst_n = 1'b0;
    #2;
    check("rst box_x", box_x, 320);
    check("rst cross_y", cross_y, 240);
    check("rst video_en", video_en, 0);
    check("rst frame_cnt", frame_cnt, 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    cyc(1);

    // WAIT_LOCK: a valid request must never see ready
    req0_valid = 1'b1; req0_sel = 1'b0; req0_x = 10'd1; req0_y = 10'd2;
    for (int i = 0; i < 100; i++) begin
      #3 check("waitlock ready0", req0_ready, 0);
      cyc(1);
    end
    req0_valid = 1'b0;
    locked = 1'b1;
    cyc(3);
    vs_pulse();
    check("warm1 video_en", video_en, 0);
    vsync = 1'b0;
    #3 check("warm2 edge video_en", video_en, 0);
    cyc(1);
    check("warm2 after video_en", video_en, 1);
    vsync = 1'b1;
    cyc(2);

    // Contention: req0 -> box, req1 -> cross
    req0_valid = 1'b1; req0_sel = 1'b0; req0_x = 10'd100; req0_y = 10'd110;
    req1_valid = 1'b1; req1_sel = 1'b1; req1_x = 10'd200; req1_y = 10'd210;
    #3 check("cont c1 ready0", req0_ready, 1);
    check("cont c1 ready1", req1_ready, 0);
    cyc(1);
    #3 check("cont c2 ready0", req0_ready, 0);
    check("cont c2 ready1", req1_ready, 1);
    check("cont c2 pend_box", pend_box, 1);
    cyc(1);
    #3 check("cont stall ready0", req0_ready, 0);
    check("cont stall ready1", req1_ready, 0);
    cyc(1);
    vsync = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    cyc(1);
    vsync = 1'b1;
    check("cont box_x", box_x, 100);
    check("cont cross_x", cross_x, 200);
    check("cont commit", commit_pulse, 1);
    cyc(2);

    // Single update with clamp
    req0_valid = 1'b1; req0_sel = 1'b0; req0_x = 10'd700; req0_y = 10'd500;
    #3 check("clamp ready0", req0_ready, 1);
    cyc(1);
    req0_valid = 1'b0;
    check("clamp pend_box", pend_box, 1);
    check("clamp box_x held", box_x, 100);
    cyc(3);
    vsync = 1'b0;
    #3 check("clamp pre commit", commit_pulse, 0);
    cyc(1);
    vsync = 1'b1;
    check("clamp box_x", box_x, 639);
    check("clamp box_y", box_y, 479);
    check("clamp commit", commit_pulse, 1);
    cyc(1);
    check("clamp commit drop", commit_pulse, 0);
    cyc(1);

    // Commit and accept in the same cycle
    req0_valid = 1'b1; req0_sel = 1'b0; req0_x = 10'd5; req0_y = 10'd5;
    cyc(1);
    req0_valid = 1'b0;
    vsync = 1'b0;
    req1_valid = 1'b1; req1_sel = 1'b1; req1_x = 10'd10; req1_y = 10'd20;
    #3 check("same ready1", req1_ready, 1);
    cyc(1);
    req1_valid = 1'b0; vsync = 1'b1;
    check("same box_x", box_x, 5);
    check("same commit", commit_pulse, 1);
    check("same pend_cross", pend_cross, 1);
    check("same cross_x held", cross_x, 200);
    cyc(2);
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    check("same2 cross_x", cross_x, 10);
    check("same2 cross_y", cross_y, 20);
    cyc(2);

    // Lock loss with a pending box update
    req0_valid = 1'b1; req0_sel = 1'b0; req0_x = 10'd50; req0_y = 10'd60;
    cyc(1);
    req0_valid = 1'b0;
    check("lock pend_box", pend_box, 1);
    locked = 1'b0;
    cyc(1);
    check("lock video_en", video_en, 0);
    check("lock pend_box", pend_box, 0);
    check("lock box_x", box_x, 5);
    cyc(5);
    locked = 1'b1;
    cyc(2);
    vs_pulse();
    check("relock warm video_en", video_en, 0);
    check("relock box_x", box_x, 5);
    vsync = 1'b0;
    cyc(1);
    vsync = 1'b1;
    check("relock video_en", video_en, 1);
    cyc(2);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req0_sel   = 1'($urandom_range(0, 1));
      req0_x     = 10'($urandom_range(0, 1023));
      req0_y     = 10'($urandom_range(0, 1023));
      req1_valid = ($urandom_range(0, 3) != 0);
      req1_sel   = 1'($urandom_range(0, 1));
      req1_x     = 10'($urandom_range(0, 1023));
      req1_y     = 10'($urandom_range(0, 1023));
      if (vs_cnt == 0) vs_cnt = $urandom_range(8, 40);
      vs_cnt--;
      vsync = (vs_cnt < 2) ? 1'b0 : 1'b1;
      if (locked) begin
        if ($urandom_range(0, 499) == 0) begin
          locked = 1'b0;
          lock_cnt = $urandom_range(1, 10);
        end
      end else if (lock_cnt == 0) begin
        locked = 1'b1;
      end else begin
        lock_cnt--;
      end
      cyc(1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; vsync = 1'b1; locked = 1'b1;
    cyc(10);

    // Asynchronous reset pulse mid-frame
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst box_x", box_x, 320);
    check("arst box_y", box_y, 240);
    check("arst cross_x", cross_x, 320);
    check("arst cross_y", cross_y, 240);
    check("arst frame_cnt", frame_cnt, 0);
    check("arst video_en", video_en, 0);
    check("arst pend_box", pend_box, 0);
    check("arst commit", commit_pulse, 0);
    #4 rst_n = 1'b1;
    cyc(8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
